imem_port_arbiter: RTL and testbench

Shares the single-port, synchronous-read instruction memory between the core fetch stage and the program loader. Sequences a boot phase, where the loader fills memory and the core is held off, and a run phase, where fetch has priority and the loader gets starvation-bounded access. Sits between the fetch stage/loader and the instruction memory array. It owns every memory enable, write strobe and address.

---
 rtl/imem_arb_pkg.sv | 23 ++
 rtl/imem_starve_ctr.sv | 29 ++
 rtl/imem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_imem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory port arbiter.
package imem_arb_pkg;

    localparam int unsigned STARVE_W = 4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LD    = 1'b1
    } owner_t;

    // Record of the access granted last cycle, used to route the read response.
    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   err;
    } resp_t;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive denied loader cycles.
module imem_starve_ctr
    import imem_arb_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [STARVE_W-1:0] cnt;

    assign at_max = (cnt == STARVE_W'(MAX));

    // Clear has priority; increment holds at MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between fetch and the loader.
// Optional boot phase (loader only, fetch held off) enabled by IMEM_ARB_BOOT_EN.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_req,
    input  logic [ADDR_W-1:0]            fetch_addr,
    output logic                         fetch_gnt,
    output logic                         fetch_rvalid,
    output logic [DATA_W-1:0]            fetch_rdata,
    output logic                         fetch_err,
    input  logic                         ld_req,
    input  logic                         ld_we,
    input  logic [ADDR_W-1:0]            ld_addr,
    input  logic [DATA_W-1:0]            ld_wdata,
    input  logic                         ld_done,
    output logic                         ld_gnt,
    output logic                         ld_rvalid,
    output logic [DATA_W-1:0]            ld_rdata,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         boot_active
);

    localparam int unsigned WA_W = ADDR_W - 2;
    localparam int unsigned MA_W = $clog2(MEM_DEPTH);

`ifdef IMEM_ARB_BOOT_EN
    localparam state_t RST_STATE = BOOT;
`else
    localparam state_t RST_STATE = RUN;
`endif

    state_t          state;
    state_t          state_nxt;
    resp_t           resp;
    logic            resp_live;
    logic            starve_max;
    logic            starve_inc;
    logic            starve_clr;
    logic [WA_W-1:0] f_word;
    logic [WA_W-1:0] l_word;
    logic            f_bad;
    logic            l_bad;

    // Word addresses and range/alignment screening for both requesters.
    assign f_word = fetch_addr[ADDR_W-1:2];
    assign l_word = ld_addr[ADDR_W-1:2];
    assign f_bad  = (fetch_addr[1:0] != 2'b00) || (f_word >= WA_W'(MEM_DEPTH));
    assign l_bad  = (ld_addr[1:0] != 2'b00) || (l_word >= WA_W'(MEM_DEPTH));

    // Phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase sequencing, same-cycle grant and memory port drive.
    always_comb begin
        state_nxt = state;
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state)
            BOOT: begin
                ld_gnt = ld_req;
                if (ld_done) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                ld_gnt    = ld_req && (!fetch_req || starve_max);
                fetch_gnt = fetch_req && !ld_gnt;
            end
            default: begin
                state_nxt = RST_STATE;
            end
        endcase

        if (rst) begin
            fetch_gnt = 1'b0;
            ld_gnt    = 1'b0;
        end

        // Bad addresses are granted but never reach the array.
        if (ld_gnt) begin
            mem_en    = !l_bad;
            mem_we    = ld_we && !l_bad;
            mem_addr  = l_word[MA_W-1:0];
            mem_wdata = ld_wdata;
        end else if (fetch_gnt) begin
            mem_en   = !f_bad;
            mem_addr = f_word[MA_W-1:0];
        end
    end

    // Starvation tracking only counts contested RUN cycles.
    assign starve_inc = (state == RUN) && ld_req && !ld_gnt;
    assign starve_clr = (state != RUN) || !ld_req || ld_gnt;

    imem_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_max)
    );

    // Capture owner of each granted read for next-cycle response routing.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp <= '0;
        end else begin
            resp.valid <= fetch_gnt || (ld_gnt && !ld_we);
            resp.owner <= ld_gnt ? OWN_LD : OWN_FETCH;
            resp.err   <= ld_gnt ? l_bad : f_bad;
        end
    end

    // Response steering; a response pending across reset is suppressed.
    assign resp_live    = resp.valid && !rst;
    assign fetch_rvalid = resp_live && (resp.owner == OWN_FETCH);
    assign fetch_err    = fetch_rvalid && resp.err;
    assign fetch_rdata  = (fetch_rvalid && !resp.err) ? mem_rdata : '0;
    assign ld_rvalid    = resp_live && (resp.owner == OWN_LD);
    assign ld_rdata     = (ld_rvalid && !resp.err) ? mem_rdata : '0;

`ifdef IMEM_ARB_BOOT_EN
    assign boot_active = rst || (state == BOOT);
`else
    assign boot_active = 1'b0;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed scoreboard bench for imem_port_arbiter with a behavioural memory.
module tb_imem_port_arbiter;

`ifdef IMEM_ARB_BOOT_EN
    localparam logic BOOT_ON = 1'b1;
`else
    localparam logic BOOT_ON = 1'b0;
`endif

    localparam logic [31:0] W0 = 32'h0000_0013;
    localparam logic [31:0] W1 = 32'h0010_0093;
    localparam logic [31:0] W2 = 32'h0020_0113;
    localparam logic [31:0] W3 = 32'h0030_0193;
    localparam logic [31:0] WL = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        fetch_err;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_done;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        boot_active;

    logic [31:0] tmem [0:1023];
    exp_t        fq[$];
    exp_t        lq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc_cnt = 0;
    logic        exp_boot;

    imem_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .fetch_err    (fetch_err),
        .ld_req       (ld_req),
        .ld_we        (ld_we),
        .ld_addr      (ld_addr),
        .ld_wdata     (ld_wdata),
        .ld_done      (ld_done),
        .ld_gnt       (ld_gnt),
        .ld_rvalid    (ld_rvalid),
        .ld_rdata     (ld_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .boot_active  (boot_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Synchronous-read single-port memory.
    always @(posedge clk) begin
        if (mem_en && mem_we) tmem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= tmem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One stimulus cycle: drive, check grant/port at negedge, queue expected response.
    task automatic cyc(input logic fr, input logic [31:0] fa,
                       input logic lr, input logic lwe, input logic [31:0] la,
                       input logic [31:0] lwd, input logic done,
                       input logic efg, input logic elg, input logic emen,
                       input logic [31:0] edata, input logic eerr);
        fetch_req  = fr;
        fetch_addr = fa;
        ld_req     = lr;
        ld_we      = lwe;
        ld_addr    = la;
        ld_wdata   = lwd;
        ld_done    = done;
        @(negedge clk);
        chk("fetch_gnt", 32'(fetch_gnt), 32'(efg));
        chk("ld_gnt", 32'(ld_gnt), 32'(elg));
        chk("mem_en", 32'(mem_en), 32'(emen));
        chk("mem_we", 32'(mem_we), 32'(elg & lwe & emen));
        chk("boot_active", 32'(boot_active), 32'(exp_boot));
        if (efg) fq.push_back('{edata, eerr, cyc_cnt + 1});
        if (elg && !lwe) lq.push_back('{edata, eerr, cyc_cnt + 1});
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        ld_req    = 1'b0;
        ld_done   = 1'b0;
    endtask

    task automatic reset_chk();
        chk("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
        chk("rst_ld_gnt", 32'(ld_gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
        chk("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_fetch_rdata", fetch_rdata, 32'd0);
        chk("rst_ld_rdata", ld_rdata, 32'd0);
        chk("rst_boot_active", 32'(boot_active), 32'(BOOT_ON));
    endtask

    // Response monitor: every rvalid must match the oldest expectation, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fetch_rvalid !== 1'b0) begin
                if (fq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fetch_rvalid_unexpected actual=%b expected=0 t=%0t", fetch_rvalid, $time);
                end else begin
                    e = fq.pop_front();
                    chk("fetch_rdata", fetch_rdata, e.data);
                    chk("fetch_err", 32'(fetch_err), 32'(e.err));
                    chk("fetch_latency", 32'(cyc_cnt), 32'(e.due));
                end
            end
            if (ld_rvalid !== 1'b0) begin
                if (lq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ld_rvalid_unexpected actual=%b expected=0 t=%0t", ld_rvalid, $time);
                end else begin
                    e = lq.pop_front();
                    chk("ld_rdata", ld_rdata, e.data);
                    chk("ld_latency", 32'(cyc_cnt), 32'(e.due));
                end
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        ld_req     = 1'b0;
        ld_we      = 1'b0;
        ld_addr    = '0;
        ld_wdata   = '0;
        ld_done    = 1'b0;
        exp_boot   = BOOT_ON;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_chk();
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef IMEM_ARB_BOOT_EN
        // Boot fill with fetch held off; last write coincides with ld_done.
        cyc(1, 32'h0, 1, 1, 32'h0, W0, 0, 0, 1, 1, 0, 0);
        cyc(1, 32'h0, 1, 1, 32'h4, W1, 0, 0, 1, 1, 0, 0);
        cyc(1, 32'h0, 0, 0, 32'h0, 0,  0, 0, 0, 0, 0, 0);
        cyc(1, 32'h0, 1, 1, 32'h8, W2, 0, 0, 1, 1, 0, 0);
        cyc(1, 32'h0, 1, 1, 32'hC, W3, 1, 0, 1, 1, 0, 0);
        exp_boot = 1'b0;
`else
        // Fetch served in the first cycle out of reset (bad address, error response).
        exp_boot = 1'b0;
        cyc(1, 32'h1000, 0, 0, 32'h0, 0, 1, 1, 0, 0, 0, 1);
        cyc(0, 32'h0, 1, 1, 32'h0, W0, 0, 0, 1, 1, 0, 0);
        cyc(0, 32'h0, 1, 1, 32'h4, W1, 0, 0, 1, 1, 0, 0);
        cyc(0, 32'h0, 1, 1, 32'h8, W2, 0, 0, 1, 1, 0, 0);
        cyc(0, 32'h0, 1, 1, 32'hC, W3, 0, 0, 1, 1, 0, 0);
`endif

        // Last valid word, then single and back-to-back fetches.
        cyc(0, 32'h0,   1, 1, 32'hFFC, WL, 0, 0, 1, 1, 0, 0);
        cyc(1, 32'h4,   0, 0, 32'h0, 0, 0, 1, 0, 1, W1, 0);
        cyc(1, 32'h0,   0, 0, 32'h0, 0, 0, 1, 0, 1, W0, 0);
        cyc(1, 32'h4,   0, 0, 32'h0, 0, 0, 1, 0, 1, W1, 0);
        cyc(1, 32'h8,   0, 0, 32'h0, 0, 0, 1, 0, 1, W2, 0);
        cyc(1, 32'hFFC, 0, 0, 32'h0, 0, 0, 1, 0, 1, WL, 0);

        // Loader read-back alternating with fetch; ld_done ignored in RUN.
        cyc(0, 32'h0, 1, 0, 32'hC, 0, 0, 0, 1, 1, W3, 0);
        cyc(1, 32'h0, 0, 0, 32'h0, 0, 1, 1, 0, 1, W0, 0);
        cyc(0, 32'h0, 1, 0, 32'h4, 0, 0, 0, 1, 1, W1, 0);
        cyc(1, 32'h8, 0, 0, 32'h0, 0, 0, 1, 0, 1, W2, 0);

        // Starvation: four denied cycles, forced loader grant on the fifth, twice.
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 5; i++) begin
                if (i < 5) cyc(1, 32'h8, 1, 0, 32'hC, 0, 0, 1, 0, 1, W2, 0);
                else       cyc(1, 32'h8, 1, 0, 32'hC, 0, 0, 0, 1, 1, W3, 0);
            end
        end

        // A cycle without ld_req clears the count.
        for (int i = 0; i < 3; i++) cyc(1, 32'h8, 1, 0, 32'hC, 0, 0, 1, 0, 1, W2, 0);
        cyc(1, 32'h8, 0, 0, 32'hC, 0, 0, 1, 0, 1, W2, 0);
        for (int i = 0; i < 4; i++) cyc(1, 32'h8, 1, 0, 32'hC, 0, 0, 1, 0, 1, W2, 0);
        cyc(1, 32'h8, 1, 0, 32'hC, 0, 0, 0, 1, 1, W3, 0);

        // Bad fetch addresses: granted, no memory access, error response.
        cyc(1, 32'h1002,    0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 1);
        cyc(1, 32'h1000,    0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 1);
        cyc(1, 32'h6,       0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 1);
        cyc(1, 32'hFFFFFFFC, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 1);

        // Bad loader writes (would alias word 0) are dropped.
        cyc(0, 32'h0, 1, 1, 32'h1000, 32'hBAD0BAD0, 0, 0, 1, 0, 0, 0);
        cyc(0, 32'h0, 1, 1, 32'h2,    32'h5A5A5A5A, 0, 0, 1, 0, 0, 0);
        cyc(1, 32'h0, 0, 0, 32'h0, 0, 0, 1, 0, 1, W0, 0);
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while a fetch read is in flight: its response is discarded.
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        @(negedge clk);
        chk("inflight_gnt", 32'(fetch_gnt), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        reset_chk();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        fetch_req = 1'b0;
        exp_boot  = BOOT_ON;

`ifdef IMEM_ARB_BOOT_EN
        cyc(1, 32'h4, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
`else
        cyc(1, 32'h4, 0, 0, 32'h0, 0, 0, 1, 0, 1, W1, 0);
`endif
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);

        chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
        chk("ld_queue_drained", 32'(lq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
